// File: rtl/column_reducer_pkg.sv
// rtl/column_reducer_pkg.sv - shared definitions for the column reducer datapath
package column_reducer_pkg;

    localparam int NUM_SIZE = 16;
    localparam int AGG_OP_W = 2;

    typedef enum logic [AGG_OP_W-1:0] {
        AGG_SUM   = 2'd0,
        AGG_MIN   = 2'd1,
        AGG_MAX   = 2'd2,
        AGG_COUNT = 2'd3
    } agg_op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } reducer_state_t;

endpackage

// File: rtl/column_reducer_reduce_step.sv
// rtl/column_reducer_reduce_step.sv - combinational accumulate step; SUM clamps instead of wrapping when SATURATE_EN is defined
module reduce_step
    import column_reducer_pkg::*;
#(
    parameter int ACC_W = NUM_SIZE + 16
) (
    input  logic [1:0]       op,
    input  logic [ACC_W-1:0] acc,
    input  logic [ACC_W-1:0] data,
    input  logic             cnt_sat,
    output logic [ACC_W-1:0] next_acc,
    output logic             ovf
);

    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic [ACC_W-1:0] ACC_ONE = {{(ACC_W-1){1'b0}}, 1'b1};

    logic [ACC_W-1:0] sum;

    always_comb begin
        next_acc = acc;
        ovf      = 1'b0;
        sum      = acc + data;
        case (op)
            AGG_SUM: begin
                // operands agree in sign but the result does not: signed overflow
                ovf = (acc[ACC_W-1] == data[ACC_W-1]) && (sum[ACC_W-1] != acc[ACC_W-1]);
`ifdef SATURATE_EN
                if (ovf)
                    next_acc = acc[ACC_W-1] ? ACC_MIN : ACC_MAX;
                else
                    next_acc = sum;
`else
                next_acc = sum;
`endif
            end
            AGG_MIN:   next_acc = ($signed(data) < $signed(acc)) ? data : acc;
            AGG_MAX:   next_acc = ($signed(data) > $signed(acc)) ? data : acc;
            AGG_COUNT: next_acc = cnt_sat ? acc : acc + ACC_ONE;
            default:   next_acc = acc;
        endcase
    end

endmodule

// File: rtl/column_reducer.sv
// rtl/column_reducer.sv - reduces in_last-delimited groups to SUM/MIN/MAX/COUNT; SATURATE_EN selects clamping SUM
module column_reducer
    import column_reducer_pkg::*;
#(
    parameter int W     = NUM_SIZE,
    parameter int ACC_W = NUM_SIZE + 16,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       agg_op,
    input  logic             in_valid,
    input  logic [W-1:0]     in_data,
    input  logic             in_last,
    output logic             in_ready,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [ACC_W-1:0] res_data,
    output logic [CNT_W-1:0] res_count,
    output logic             res_ovf
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [ACC_W-1:0] ACC_ONE = {{(ACC_W-1){1'b0}}, 1'b1};

    reducer_state_t   state;
    agg_op_t          op;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             ovf;

    logic [ACC_W-1:0] data_ext;
    logic [ACC_W-1:0] step_acc;
    logic             step_ovf;
    logic             cnt_sat;
    logic             beat;

    assign data_ext = ACC_W'($signed(in_data));
    assign cnt_sat  = (cnt == {CNT_W{1'b1}});
    assign beat     = in_valid && in_ready;

    reduce_step #(.ACC_W(ACC_W)) u_step (
        .op       (op),
        .acc      (acc),
        .data     (data_ext),
        .cnt_sat  (cnt_sat),
        .next_acc (step_acc),
        .ovf      (step_ovf)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            op        <= AGG_SUM;
            acc       <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            in_ready  <= 1'b0;
            res_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (beat) begin
                        op  <= agg_op_t'(agg_op);
                        acc <= (agg_op_t'(agg_op) == AGG_COUNT) ? ACC_ONE : data_ext;
                        cnt <= CNT_ONE;
                        ovf <= 1'b0;
                        if (in_last) begin
                            state     <= HOLD;
                            in_ready  <= 1'b0;
                            res_valid <= 1'b1;
                        end else begin
                            state <= ACCUM;
                        end
                    end
                end
                ACCUM: begin
                    if (beat) begin
                        acc <= step_acc;
                        cnt <= cnt_sat ? cnt : cnt + CNT_ONE;
                        ovf <= ovf | step_ovf | cnt_sat;
                        if (in_last) begin
                            state     <= HOLD;
                            in_ready  <= 1'b0;
                            res_valid <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (res_ready) begin
                        state     <= IDLE;
                        res_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b0;
                    res_valid <= 1'b0;
                end
            endcase
        end
    end

    assign res_data  = acc;
    assign res_count = cnt;
    assign res_ovf   = ovf;

endmodule

// File: tb/tb_column_reducer.sv
// tb/tb_column_reducer.sv - randomized and directed checks of column_reducer against a queue-based model
module tb_column_reducer;

    localparam int W     = 8;
    localparam int ACC_W = 8;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic [1:0]       agg_op;
    logic             in_valid;
    logic [W-1:0]     in_data;
    logic             in_last;
    logic             in_ready;
    logic             res_valid;
    logic             res_ready;
    logic [ACC_W-1:0] res_data;
    logic [CNT_W-1:0] res_count;
    logic             res_ovf;

    int total = 0;
    int bad   = 0;

    column_reducer #(.W(W), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .agg_op    (agg_op),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_count (res_count),
        .res_ovf   (res_ovf)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic over the whole group
    function automatic void model(input int op, input int vals[$],
                                  output int rd, output int rc, output int ro);
        int lim_hi = (1 << (ACC_W-1)) - 1;
        int lim_lo = -(1 << (ACC_W-1));
        int span   = 1 << ACC_W;
        int acc    = vals[0];
        int s;
        ro = 0;
        rc = vals.size();
        for (int i = 1; i < vals.size(); i++) begin
            case (op)
                0: begin
                    s = acc + vals[i];
                    if (s > lim_hi || s < lim_lo) begin
                        ro = 1;
`ifdef SATURATE_EN
                        acc = (s > lim_hi) ? lim_hi : lim_lo;
`else
                        acc = ((s - lim_lo + 2*span) % span) + lim_lo;
`endif
                    end else begin
                        acc = s;
                    end
                end
                1: if (vals[i] < acc) acc = vals[i];
                2: if (vals[i] > acc) acc = vals[i];
                default: ;
            endcase
        end
        rd = (op == 3) ? vals.size() : acc;
    endfunction

    task automatic send_beat(input int v, input bit last, input int op);
        int guard = 0;
        in_valid = 1'b1;
        in_data  = W'(v);
        in_last  = last;
        agg_op   = 2'(op);
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) check_eq("in_ready_timeout", 0, 1);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic run_group(input string tag, input int op, input int vals[$],
                             input int hold, input int gaps, input bit toggle);
        int rd, rc, ro;
        model(op, vals, rd, rc, ro);
        for (int i = 0; i < vals.size(); i++) begin
            send_beat(vals[i], i == vals.size() - 1, (toggle && i > 0) ? int'($urandom_range(3)) : op);
            if (i < vals.size() - 1) begin
                for (int g = 0; g < gaps; g++) begin
                    if (toggle) agg_op = 2'($urandom_range(3));
                    @(negedge clk);
                end
            end
        end
        // one cycle after the last accepted beat
        check_eq({tag, "_valid"}, int'(res_valid), 1);
        check_eq({tag, "_data"},  int'($signed(res_data)), rd);
        check_eq({tag, "_count"}, int'(res_count), rc);
        check_eq({tag, "_ovf"},   int'(res_ovf), ro);
        check_eq({tag, "_inrdy"}, int'(in_ready), 0);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check_eq({tag, "_hold_valid"}, int'(res_valid), 1);
            check_eq({tag, "_hold_data"},  int'($signed(res_data)), rd);
            check_eq({tag, "_hold_count"}, int'(res_count), rc);
            check_eq({tag, "_hold_inrdy"}, int'(in_ready), 0);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check_eq({tag, "_post_valid"}, int'(res_valid), 0);
        check_eq({tag, "_post_inrdy"}, int'(in_ready), 1);
    endtask

    initial begin
        int q[$];
        reset     = 1'b1;
        agg_op    = 2'd0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        res_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_eq("rst_inrdy", int'(in_ready), 0);
        check_eq("rst_valid", int'(res_valid), 0);
        check_eq("rst_data",  int'(res_data), 0);
        check_eq("rst_count", int'(res_count), 0);
        check_eq("rst_ovf",   int'(res_ovf), 0);
        reset = 1'b0;

        q = '{3, -5, 10};     run_group("sum3", 0, q, 0, 0, 0);
        q = '{-7, -2, -9};    run_group("max3", 2, q, 0, 0, 0);
        q = '{4, 1, 6};       run_group("min3", 1, q, 0, 0, 0);
        q = '{42};            run_group("cnt1", 3, q, 5, 0, 0);
        q = '{127, 127};      run_group("sumovf", 0, q, 0, 0, 0);
        q = '{-128, -1, -50}; run_group("sumneg", 0, q, 1, 0, 0);
        q = '{9, 20, -3, 7};  run_group("toggle", 2, q, 0, 2, 1);

        send_beat(11, 1'b0, 0);
        send_beat(22, 1'b0, 0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_eq("midrst_valid", int'(res_valid), 0);
        check_eq("midrst_count", int'(res_count), 0);
        check_eq("midrst_inrdy", int'(in_ready), 0);
        q = '{5};             run_group("afterrst", 0, q, 0, 0, 0);

        for (int g = 0; g < 40; g++) begin
            int n = $urandom_range(1, 8);
            q.delete();
            for (int i = 0; i < n; i++) q.push_back(int'($urandom_range(255)) - 128);
            run_group("rand", $urandom_range(3), q, $urandom_range(3),
                      $urandom_range(2), 1'($urandom_range(1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
